fetch_stage: RTL
================

Name: fetch_stage

Overview:
- Instruction-fetch stage of the 16-bit MIPS core; sits directly upstream of the instruction ROM.
- Owns the program counter and drives the byte address `pc` into the ROM. The ROM reads `pc[4:1]` combinationally.
- Captures the returned 16-bit instruction into the IF/ID pipeline register for the decoder.
- Handles pipeline stall, flush and branch/jump redirect.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset (bit 0 must be 0)
- PC_STEP, 2, byte increment per sequential fetch (16-bit instructions)

Ports:
- clk  in  1  core clock, rising-edge
- rst_n  in  1  synchronous active-low reset
- stall  in  1  hazard unit: hold PC and IF/ID contents
- flush  in  1  invalidate IF/ID (taken branch resolved downstream)
- redirect  in  1  load PC from redirect_pc (branch taken / jump)
- redirect_pc  in  16  new fetch address
- pc  out  16  current fetch address to instruction ROM
- instr_in  in  16  instruction returned by ROM for `pc` (same cycle, combinational)
- if_id_instr  out  16  registered instruction to decode
- if_id_pc_plus2  out  16  registered pc+PC_STEP of that instruction
- if_id_valid  out  1  IF/ID holds a real instruction

Behaviour:
- All state updates happen on the rising edge of clk. Reset is sampled only on that edge.
- Reset (rst_n=0):
  - pc <= RESET_PC.
  - if_id_instr <= 16'h0000, if_id_pc_plus2 <= 16'h0000, if_id_valid <= 0.
  - Reset overrides every other input.
  - Reset mid-stall or mid-redirect discards all pending state.
- PC next-value priority, highest first:
  1. reset
  2. redirect: pc <= {redirect_pc[15:1],1'b0}. Bit 0 is forced to 0; a misaligned target is silently aligned.
  3. stall: pc holds.
  4. otherwise: pc <= pc + PC_STEP, modulo 2^16. 16'hFFFE wraps to 16'h0000 with no flag.
- IF/ID next-value priority, highest first:
  1. reset
  2. redirect or flush: if_id_valid <= 0 and if_id_instr <= 16'h0000 (NOP). if_id_pc_plus2 holds.
  3. stall: all IF/ID fields hold, valid included.
  4. otherwise: if_id_instr <= instr_in, if_id_pc_plus2 <= pc + PC_STEP, if_id_valid <= 1.
- Simultaneous events:
  - redirect and stall: redirect wins for PC and IF/ID is squashed. The stalled instruction belongs to a wrong path.
  - flush and stall: IF/ID squashed; PC holds.
  - flush without redirect: PC advances normally.
- Latency:
  - The instruction at address A appears on if_id_instr one edge after pc==A is presented with no stall.
  - After a redirect the first valid instruction appears 2 edges later: redirect edge loads PC, next edge loads IF/ID.
- First edge after reset release latches ROM[RESET_PC] with valid=1.
- No internal FSM beyond the PC and IF/ID registers. stall/flush/redirect are level-sampled each edge.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN
- When defined, two extra outputs are added:
  - fetch_cnt [15:0]: counts edges where IF/ID loaded a valid instruction.
  - stall_cnt [15:0]: counts edges where stall=1 and redirect=0.
  - Both saturate at 16'hFFFF and clear on reset.
- When undefined, neither port nor counter logic exists. All other behaviour is identical.

Test Plan:
- Reset hold then release, ROM[0]=16'h1234, ROM[1]=16'h5678 -> after edge 1: pc=0002, if_id_instr=1234, pc_plus2=0002, valid=1. After edge 2: instr=5678, pc=0004.
- stall=1 for 3 cycles at pc=0006 -> pc stays 0006 and IF/ID unchanged for 3 edges. Fetch resumes with ROM[3] on release.
- redirect=1, redirect_pc=16'h0011, with stall=1 -> pc=0010, valid=0, instr=0000. Next edge: instr=ROM[8], valid=1, pc_plus2=0012.
- flush=1 alone at pc=0008 -> valid=0 and pc advances to 000A. Next edge: ROM[5] valid.
- Wrap: redirect to FFFE, ROM content wraps -> next pc=0000, pc_plus2=0000, no error.
- With FETCH_PERF_CNT_EN: 10 normal fetches + 4 stalls -> fetch_cnt=10, stall_cnt=4. rst_n=0 clears both to 0.

Source files
------------

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage: PC register and IF/ID pipeline register
// Optional macro FETCH_PERF_CNT_EN adds saturating fetch_cnt/stall_cnt outputs.
module fetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] PC_STEP  = 16'd2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic [15:0] pc,
  input  logic [15:0] instr_in,
  output logic [15:0] if_id_instr,
  output logic [15:0] if_id_pc_plus2,
`ifdef FETCH_PERF_CNT_EN
  output logic        if_id_valid,
  output logic [15:0] fetch_cnt,
  output logic [15:0] stall_cnt
`else
  output logic        if_id_valid
`endif
);

  logic [15:0] pc_seq;
  logic        squash;
  logic        load;

  assign pc_seq = pc + PC_STEP;
  assign squash = redirect | flush;
  assign load   = ~squash & ~stall;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (redirect) begin
      pc <= {redirect_pc[15:1], 1'b0};
    end else if (!stall) begin
      pc <= pc_seq;
    end
  end

  // A squash keeps pc_plus2 so only valid and the NOP encoding change.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      if_id_instr    <= 16'h0000;
      if_id_pc_plus2 <= 16'h0000;
      if_id_valid    <= 1'b0;
    end else if (squash) begin
      if_id_instr <= 16'h0000;
      if_id_valid <= 1'b0;
    end else if (load) begin
      if_id_instr    <= instr_in;
      if_id_pc_plus2 <= pc_seq;
      if_id_valid    <= 1'b1;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_cnt <= 16'h0000;
      stall_cnt <= 16'h0000;
    end else begin
      if (load && fetch_cnt != 16'hFFFF) fetch_cnt <= fetch_cnt + 16'd1;
      if (stall && !redirect && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule
